inst_fetch: RTL and testbench

//   Fetch stage directly upstream of the synchronous-read instruction memory (imem).

---
 rtl/inst_fetch.sv | 95 +++++++++
 tb/tb_inst_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Fetch stage in front of a synchronous-read instruction memory. It owns the
//   PC, drives the imem word address and hides the one-cycle imem read latency.
//   It presents {pc, instruction} to decode over a valid/ready handshake. It
//   holds the presented instruction while decode stalls, and it inserts one
//   bubble cycle when a branch or jump redirects fetch.
//
// Ports
//   w_clk          in   1       clock, all state on posedge
//   w_rst_n        in   1       asynchronous active-low reset
//   w_redirect     in   1       redirect fetch to w_redirect_pc this cycle
//   w_redirect_pc  in   32      redirect target (byte address, [1:0] ignored)
//   w_imem_inst    in   32      imem registered read data (previous cycle's address)
//   r_imem_addr    out  ADDR_W  imem word address presented this cycle
//   r_out_valid    out  1       r_out_pc/r_out_inst hold a fetched instruction
//   w_out_ready    in   1       decode accepts when r_out_valid && w_out_ready
//   r_out_pc       out  32      byte PC of the presented instruction
//   r_out_inst     out  32      presented instruction (imem data pass-through)
//   r_fetch_cnt    out  32      completed handshakes, wraps at 2**32
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_redirect,
  input  logic [31:0]       w_redirect_pc,
  input  logic [31:0]       w_imem_inst,
  output logic [ADDR_W-1:0] r_imem_addr,
  output logic              r_out_valid,
  input  logic              w_out_ready,
  output logic [31:0]       r_out_pc,
  output logic [31:0]       r_out_inst,
  output logic [31:0]       r_fetch_cnt
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] BUBBLE = 2'd2;

  logic [1:0]  state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] out_pc_reg;
  logic [31:0] fetch_cnt_reg;

  logic        stall;
  logic        accept;

  // Redirect targets are word aligned by dropping the low two bits.
  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = ^w_redirect_pc[1:0];

  // Valid is decoded from registered state only, so it never depends on inputs.
  assign r_out_valid = (state_reg == RUN);
  assign stall       = r_out_valid && !w_out_ready;
  assign accept      = r_out_valid && w_out_ready;

  // While stalled, re-read the word already on display so the imem output
  // register (and therefore r_out_inst) stays stable.
  assign r_imem_addr = stall ? out_pc_reg[ADDR_W+1:2] : fetch_pc_reg[ADDR_W+1:2];

  assign r_out_pc    = out_pc_reg;
  assign r_out_inst  = w_imem_inst;
  assign r_fetch_cnt = fetch_cnt_reg;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_reg    <= BOOT;
      fetch_pc_reg <= RESET_PC;
      out_pc_reg   <= RESET_PC;
    end else if (w_redirect) begin
      // The data read this cycle belongs to the old stream, so spend one
      // BUBBLE cycle while imem reads the target word.
      fetch_pc_reg <= {w_redirect_pc[31:2], 2'b00};
      state_reg    <= BUBBLE;
    end else if (!stall) begin
      out_pc_reg   <= fetch_pc_reg;
      fetch_pc_reg <= fetch_pc_reg + 32'd4;
      state_reg    <= RUN;
    end
  end

  // A handshake on a redirect cycle still counts; only the stream after it is
  // discarded.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      fetch_cnt_reg <= 32'd0;
    end else if (accept) begin
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Bench for inst_fetch with a behavioural synchronous-read imem. A table of
//   per-cycle records {inputs, expected outputs} is applied one row per clock.
//   Hand-written sequences then cover reset during a stall and the replay that
//   follows.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int ADDR_W = 6;

  logic              w_clk;
  logic              w_rst_n;
  logic              w_redirect;
  logic [31:0]       w_redirect_pc;
  logic [31:0]       w_imem_inst;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_out_valid;
  logic              w_out_ready;
  logic [31:0]       r_out_pc;
  logic [31:0]       r_out_inst;
  logic [31:0]       r_fetch_cnt;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .w_redirect    (w_redirect),
    .w_redirect_pc (w_redirect_pc),
    .w_imem_inst   (w_imem_inst),
    .r_imem_addr   (r_imem_addr),
    .r_out_valid   (r_out_valid),
    .w_out_ready   (w_out_ready),
    .r_out_pc      (r_out_pc),
    .r_out_inst    (r_out_inst),
    .r_fetch_cnt   (r_fetch_cnt)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Behavioural imem: one-cycle registered read.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 32'hA000_0000 | k;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0020_81B3;
  end
  always @(posedge w_clk) w_imem_inst <= mem[r_imem_addr];

  localparam logic [31:0] W0 = 32'h0010_0093;
  localparam logic [31:0] W1 = 32'h0020_0113;
  localparam logic [31:0] W2 = 32'h0020_81B3;

  typedef struct {
    logic              redir;
    logic [31:0]       redir_pc;
    logic              ready;
    logic              exp_valid;
    logic [31:0]       exp_pc;
    logic [31:0]       exp_inst;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_cnt;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    // Rows are per-cycle: inputs driven this cycle, outputs expected this cycle.
    //               redir pc          rdy val pc            inst          addr cnt
    vecs[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        6'd0,  32'd0};  // BOOT
    vecs[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   W0,           6'd1,  32'd0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   W1,           6'd1,  32'd1};  // stall
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   W1,           6'd1,  32'd1};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   W1,           6'd1,  32'd1};
    vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   W1,           6'd2,  32'd1};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   W2,           6'd3,  32'd2};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   32'hA0000003, 6'd4,  32'd3};
    vecs[8]  = '{1'b1, 32'h0,   1'b1, 1'b1, 32'h10,  32'hA0000004, 6'd5,  32'd4};  // redirect 0
    vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        6'd0,  32'd5};  // bubble
    vecs[10] = '{1'b1, 32'h8,   1'b1, 1'b1, 32'h0,   W0,           6'd1,  32'd5};  // redirect 8 at pc0
    vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        6'd2,  32'd6};
    vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   W2,           6'd3,  32'd6};
    vecs[13] = '{1'b1, 32'hA,   1'b0, 1'b1, 32'hC,   32'hA0000003, 6'd3,  32'd7};  // dropped
    vecs[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        6'd2,  32'd7};
    vecs[15] = '{1'b1, 32'hFC,  1'b1, 1'b1, 32'h8,   W2,           6'd3,  32'd7};
    vecs[16] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        6'd63, 32'd8};
    vecs[17] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hFC,  32'hA000003F, 6'd0,  32'd8};
    vecs[18] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, W0,           6'd1,  32'd9};  // alias word 0
    vecs[19] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, W1,           6'd2,  32'd10};
    vecs[20] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h108, W2,           6'd2,  32'd11}; // stall at 0x108

    w_rst_n       = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = 32'h0;
    w_out_ready   = 1'b1;

    repeat (2) @(negedge w_clk);
    chk("rst_valid", -1, {31'd0, r_out_valid}, 32'd0);
    chk("rst_cnt",   -1, r_fetch_cnt, 32'd0);
    chk("rst_pc",    -1, r_out_pc, 32'h0);
    w_rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      w_redirect    = vecs[i].redir;
      w_redirect_pc = vecs[i].redir_pc;
      w_out_ready   = vecs[i].ready;
      #1;
      $display("cycle %0d: redir=%0b rdy=%0b valid=%0b pc=0x%08h inst=0x%08h addr=%0d cnt=%0d",
               i, w_redirect, w_out_ready, r_out_valid, r_out_pc, r_out_inst,
               r_imem_addr, r_fetch_cnt);
      chk("valid", i, {31'd0, r_out_valid}, {31'd0, vecs[i].exp_valid});
      chk("addr",  i, {26'd0, r_imem_addr}, {26'd0, vecs[i].exp_addr});
      chk("cnt",   i, r_fetch_cnt, vecs[i].exp_cnt);
      if (vecs[i].exp_valid) begin
        chk("pc",   i, r_out_pc, vecs[i].exp_pc);
        chk("inst", i, r_out_inst, vecs[i].exp_inst);
      end
      @(negedge w_clk);
    end

    // Still stalled at 0x108: the presentation must hold.
    #1;
    $display("stall hold: valid=%0b pc=0x%08h inst=0x%08h cnt=%0d",
             r_out_valid, r_out_pc, r_out_inst, r_fetch_cnt);
    chk("hold_valid", 21, {31'd0, r_out_valid}, 32'd1);
    chk("hold_pc",    21, r_out_pc, 32'h108);
    chk("hold_inst",  21, r_out_inst, W2);
    chk("hold_cnt",   21, r_fetch_cnt, 32'd11);

    // Asynchronous reset in the middle of the stall takes effect immediately.
    #2 w_rst_n = 1'b0;
    #1;
    $display("mid-stall reset: valid=%0b pc=0x%08h addr=%0d cnt=%0d",
             r_out_valid, r_out_pc, r_imem_addr, r_fetch_cnt);
    chk("mrst_valid", 22, {31'd0, r_out_valid}, 32'd0);
    chk("mrst_cnt",   22, r_fetch_cnt, 32'd0);
    chk("mrst_addr",  22, {26'd0, r_imem_addr}, 32'd0);

    @(negedge w_clk);
    w_rst_n     = 1'b1;
    w_out_ready = 1'b1;
    #1;
    $display("release: valid=%0b addr=%0d cnt=%0d", r_out_valid, r_imem_addr, r_fetch_cnt);
    chk("rel_valid", 23, {31'd0, r_out_valid}, 32'd0);

    @(negedge w_clk);
    #1;
    $display("replay: valid=%0b pc=0x%08h inst=0x%08h cnt=%0d",
             r_out_valid, r_out_pc, r_out_inst, r_fetch_cnt);
    chk("rep_valid", 24, {31'd0, r_out_valid}, 32'd1);
    chk("rep_pc",    24, r_out_pc, 32'h0);
    chk("rep_inst",  24, r_out_inst, W0);
    chk("rep_cnt",   24, r_fetch_cnt, 32'd0);

    @(negedge w_clk);
    #1;
    $display("replay+1: valid=%0b pc=0x%08h inst=0x%08h cnt=%0d",
             r_out_valid, r_out_pc, r_out_inst, r_fetch_cnt);
    chk("rep1_pc",   25, r_out_pc, 32'h4);
    chk("rep1_inst", 25, r_out_inst, W1);
    chk("rep1_cnt",  25, r_fetch_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
